// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single write port of sync_fifo among NUM_REQ producers.
// Grants one requester at a time for a bounded burst and stalls on FIFO full without dropping words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic [NUM_REQ-1:0]        last_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  output logic                      busy_o,
  output logic [NUM_REQ-1:0]        owner_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   owner_idx;
  logic               own_req;
  logic               own_last;
  logic               burst_end;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = NUM_REQ'(1) << win_idx;

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q[k]) owner_idx = PTR_W'(k);
    end
  end

  assign own_req  = |(owner_q & req_i);
  assign own_last = |(owner_q & last_i);

  // Full stalls the grant but keeps ownership; the owner's data is only a datapath mux.
  assign gnt_o        = (state_q == ST_GRANT && !fifo_full_i) ? (owner_q & req_i) : '0;
  assign fifo_wr_en_o = |gnt_o;

  always_comb begin
    fifo_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q[k]) fifo_data_o = data_i[k*DATA_W +: DATA_W];
    end
  end

  assign burst_end = (state_q == ST_GRANT) &&
                     (!own_req ||
                      (fifo_wr_en_o && (own_last || cnt_q == CNT_W'(MAX_BURST - 1))));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      ST_ARB: begin
        if (win_found) begin
          state_d = ST_GRANT;
          owner_d = win_onehot;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (burst_end) begin
          state_d = ST_ARB;
          owner_d = '0;
          cnt_d   = '0;
          ptr_d   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
        end else if (fifo_wr_en_o) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
        owner_d = '0;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears all state at once, so the grant logic drops
  // to zero the instant rst_n falls, even mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o  = (state_q == ST_GRANT);
  assign owner_o = owner_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of `sync_fifo` among `NUM_REQ` producers. It grants the port to one requester at a time for a bounded burst and honours `full_o` backpressure so no word is ever dropped. Its write outputs connect directly to the FIFO's `wr_en_i`/`data_i` in the same clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 8: word width, equal to the FIFO data width.
- `MAX_BURST`, default 4: maximum words accepted per grant (1..15).
- `clk` in 1: the only clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_i` in NUM_REQ: requester k has a valid word on its data slice.
- `data_i` in NUM_REQ*DATA_W: packed words; requester k uses bits `[k*DATA_W +: DATA_W]`.
- `last_i` in NUM_REQ: requester k's current word ends its burst.
- `gnt_o` out NUM_REQ: one-hot, combinational; a bit is high when requester k's word is accepted this cycle.
- `fifo_full_i` in 1: connects to FIFO `full_o`.
- `fifo_wr_en_o` out 1: connects to FIFO `wr_en_i`; equals `|gnt_o`.
- `fifo_data_o` out DATA_W: connects to FIFO `data_i`; carries the owner's data slice, or 0 when idle.
- `busy_o` out 1: registered; high in the GRANT state.
- `owner_o` out NUM_REQ: registered one-hot owner; 0 in the ARB state.

## Operation
- Registered state is:
  - FSM state: ARB or GRANT.
  - `owner_o`.
  - Round-robin pointer `ptr` (index, 0..NUM_REQ-1).
  - Burst counter `cnt` (0..MAX_BURST).
- **ARB state.**
  - No grants are issued.
  - The winner is the first index with `req_i` high, searching `ptr`, `ptr+1`, … modulo NUM_REQ.
  - If a winner exists: at the clock edge, `owner_o` takes the winner, `cnt` is set to 0 and the FSM goes to GRANT.
  - If no requester is active, the FSM stays in ARB.
- **GRANT state, owner k.**
  - `gnt_o[k] = req_i[k] & ~fifo_full_i`. All other `gnt_o` bits are 0.
  - On every accepted word, `cnt` increments.
  - The burst ends at the edge of an accepted word when `last_i[k]` is high, or when `cnt+1 == MAX_BURST`.
  - The burst also ends at any edge where `req_i[k]` is low.
  - On burst end: the FSM goes to ARB, `ptr` becomes `(k+1) mod NUM_REQ`, and `owner_o` is cleared.
- **Full handling.** While `fifo_full_i` is high, ownership is kept and `cnt` is frozen. The burst resumes when full drops, with no timeout.
- **Requester rule.** A requester must hold `req_i`, its data slice and `last_i` stable until it sees its `gnt_o` bit. A word counts as transferred exactly in the cycle `gnt_o` is high.
- **Simultaneous full and last.** No transfer occurs and the burst does not end.
- **Reset (`rst_n` low, at any time including mid-burst).**
  - Asynchronously forces the FSM to ARB, `ptr` = 0, `cnt` = 0 and `owner_o` = 0.
  - All outputs go to 0 immediately: `gnt_o`, `fifo_wr_en_o`, `fifo_data_o`, `busy_o`, `owner_o`.
  - A word presented during reset is not written.

## Timing
- A new grant costs one ARB cycle. The first transfer is possible on the cycle after the winner's `req_i` is sampled in ARB.
- Within a burst, up to one word is transferred per cycle with zero added latency: the FIFO samples the word at the same edge as the grant.
- Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
- With `fifo_full_i` low, a continuously requesting requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles before its ARB win.
- The combinational path is `req_i`/`fifo_full_i` → `gnt_o` → `fifo_wr_en_o`. There is no combinational path from `data_i` to any control output.

## Test plan
- **Reset.**
  - Stimulus: hold `rst_n` low with `req_i`=4'b1111.
  - Required: all outputs are 0. After release, the first ARB win goes to requester 0.
- **Single requester burst.**
  - Stimulus: requester 2 presents 0x10, 0x11, 0x12, with `last_i` on 0x12.
  - Required: one ARB cycle, then `gnt_o`=4'b0100 for 3 consecutive cycles. The FIFO then reads back 0x10, 0x11, 0x12 and `busy_o` falls.
- **Fairness.**
  - Stimulus: all 4 requesters active continuously, no `last_i`, MAX_BURST=4.
  - Required: owner order 0, 1, 2, 3, 0, …, with 4 words each and exactly one idle cycle between bursts.
- **Backpressure.**
  - Stimulus: requester 0 streams 0x00..0x09 into an 8-deep FIFO with no reads.
  - Required: 8 words are written, then `gnt_o`=0 while full. After 2 reads, 2 more words are accepted. The readback is 0x00..0x09 in order, with no loss or duplication.
- **Early release.**
  - Stimulus: requester 1 drops `req_i` after 2 of 4 words while requester 3 is waiting.
  - Required: `owner_o` clears on the next edge and the next grant goes to requester 3.
- **Mid-burst reset.**
  - Stimulus: assert `rst_n` low during requester 1's second word.
  - Required: `fifo_wr_en_o` drops immediately. After release, arbitration restarts from requester 0.
